// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit
// ----------------------------------------------------------------------------
// Multi-cycle instruction fetch stage that sits directly downstream of the
// program counter. On a fetch request it captures the PC, issues a single
// valid/ready request to instruction memory, waits for the one-cycle response,
// latches the returned word into the instruction register and pulses PC_en
// for one cycle so the PC advances exactly once per completed fetch.
// Flushes (taken branches), misaligned PCs and memory timeouts are handled
// without ever producing a spurious PC_en.
//
// Parameters
//   ADDR_W   width of PC / memory address
//   DATA_W   instruction word width
//   TIMEOUT  cycles spent in WAIT/DRAIN without a response before faulting
//            (1 .. 2**CNT_W-1)
//   CNT_W    width of the timeout counter
//
// Ports
//   CLK            in   clock, rising edge
//   Reset_n        in   asynchronous active-low reset
//   PC             in   current PC from the program counter
//   Fetch_go       in   start a fetch (level, only looked at while idle)
//   Flush          in   abandon the current fetch (branch taken)
//   imem_req_valid out  request valid towards instruction memory
//   imem_req_ready in   memory accepts the request
//   imem_addr      out  request address (PC captured at fetch start)
//   imem_rsp_valid in   response valid, one cycle per accepted request
//   imem_rsp_data  in   response instruction word
//   Instr          out  instruction register
//   Instr_valid    out  Instr holds a fetched, unflushed word
//   PC_en          out  one-cycle advance enable for the program counter
//   Busy           out  a fetch is in progress (not IDLE, not ERROR)
//   Fault          out  one-cycle pulse on misaligned PC, sticky on timeout
// ============================================================================
module instr_fetch_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] PC,
    input  logic              Fetch_go,
    input  logic              Flush,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic [DATA_W-1:0] Instr,
    output logic              Instr_valid,
    output logic              PC_en,
    output logic              Busy,
    output logic              Fault
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    // The counter is cleared at the handshake and incremented once per
    // response-less cycle; reaching TIMEOUT-1 in such a cycle means TIMEOUT
    // cycles have gone by without a response.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            imem_req_valid <= 1'b0;
            imem_addr      <= '0;
            Instr          <= '0;
            Instr_valid    <= 1'b0;
            PC_en          <= 1'b0;
            Busy           <= 1'b0;
            Fault          <= 1'b0;
        end else begin
            // PC_en is a strict single-cycle pulse.
            PC_en <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    // Misalign fault is a pulse: cleared on every idle cycle
                    // unless re-raised below.
                    Fault <= 1'b0;
                    if (Flush) begin
                        // Flush takes priority over a concurrent Fetch_go.
                        Instr_valid <= 1'b0;
                    end else if (Fetch_go) begin
                        if (PC[1:0] == 2'b00) begin
                            imem_addr      <= PC;
                            Instr_valid    <= 1'b0;
                            imem_req_valid <= 1'b1;
                            Busy           <= 1'b1;
                            state          <= S_REQ;
                        end else begin
                            Fault <= 1'b1;
                        end
                    end
                end

                S_REQ: begin
                    // imem_addr is not touched here, so it stays stable for
                    // the whole time the request is pending.
                    if (imem_req_ready) begin
                        // Once the handshake happens the memory owes a
                        // response; a flush in this same cycle must still
                        // drain it.
                        imem_req_valid <= 1'b0;
                        cnt            <= '0;
                        state          <= Flush ? S_DRAIN : S_WAIT;
                    end else if (Flush) begin
                        imem_req_valid <= 1'b0;
                        Busy           <= 1'b0;
                        state          <= S_IDLE;
                    end
                end

                S_WAIT, S_DRAIN: begin
                    cnt <= cnt + 1'b1;
                    if (imem_rsp_valid) begin
                        // Only an unflushed response in WAIT commits.
                        if ((state == S_WAIT) && !Flush) begin
                            Instr       <= imem_rsp_data;
                            Instr_valid <= 1'b1;
                            PC_en       <= 1'b1;
                        end
                        Busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        Fault <= 1'b1;
                        Busy  <= 1'b0;
                        state <= S_ERROR;
                    end else if ((state == S_WAIT) && Flush) begin
                        state <= S_DRAIN;
                    end
                end

                S_ERROR: begin
                    // Terminal until reset.
                    Fault          <= 1'b1;
                    Busy           <= 1'b0;
                    imem_req_valid <= 1'b0;
                end

                default: begin
                    state          <= S_IDLE;
                    imem_req_valid <= 1'b0;
                    Busy           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          CLK = 1'b0;
    logic          Reset_n;
    logic [AW-1:0] PC;
    logic          Fetch_go;
    logic          Flush;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_addr;
    logic          imem_rsp_valid;
    logic [DW-1:0] imem_rsp_data;
    logic [DW-1:0] Instr;
    logic          Instr_valid;
    logic          PC_en;
    logic          Busy;
    logic          Fault;

    instr_fetch_unit #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TMO),
        .CNT_W  (8)
    ) dut (
        .CLK           (CLK),
        .Reset_n       (Reset_n),
        .PC            (PC),
        .Fetch_go      (Fetch_go),
        .Flush         (Flush),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .Instr         (Instr),
        .Instr_valid   (Instr_valid),
        .PC_en         (PC_en),
        .Busy          (Busy),
        .Fault         (Fault)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    // Transaction-level reference state.
    logic [DW-1:0] exp_instr;
    logic          exp_valid;
    int            exp_pcen;
    int            pcen_seen = 0;

    always @(negedge CLK) if (PC_en === 1'b1) pcen_seen++;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        Fetch_go       = 1'b0;
        Flush          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, imem_req_valid, 0);
        chk({tag, "_addr"},      imem_addr,      0);
        chk({tag, "_instr"},     Instr,          0);
        chk({tag, "_ivalid"},    Instr_valid,    0);
        chk({tag, "_pc_en"},     PC_en,          0);
        chk({tag, "_busy"},      Busy,           0);
        chk({tag, "_fault"},     Fault,          0);
    endtask

    // One fetch transaction described at the transaction level.
    //   rdly  : cycles ready is held low before the handshake
    //   sdly  : response-less cycles after the handshake (after flush for mode 3)
    //   fmode : 0 none, 1 flush before handshake, 2 flush in handshake cycle,
    //           3 flush in first WAIT cycle, 4 flush together with response
    task automatic run_fetch(input logic [AW-1:0] pc, input logic [DW-1:0] data,
                             input int rdly, input int sdly, input int fmode);
        logic [31:0] r;
        PC       = pc;
        Fetch_go = 1'b1;
        tick();
        Fetch_go = 1'b0;

        if (pc[1:0] != 2'b00) begin
            chk("mis_fault",     Fault,          1);
            chk("mis_req_valid", imem_req_valid, 0);
            chk("mis_busy",      Busy,           0);
            chk("mis_ivalid",    Instr_valid,    exp_valid);
            tick();
            chk("mis_fault_clr", Fault,          0);
            chk("mis_req_after", imem_req_valid, 0);
            return;
        end

        exp_valid = 1'b0;
        chk("req_valid", imem_req_valid, 1);
        chk("req_addr",  imem_addr,      pc);
        chk("req_busy",  Busy,           1);

        if (fmode == 1) begin
            Flush = 1'b1;
            tick();
            Flush = 1'b0;
            chk("f1_req_valid", imem_req_valid, 0);
            chk("f1_busy",      Busy,           0);
            chk("f1_ivalid",    Instr_valid,    0);
            chk("f1_pc_en",     PC_en,          0);
            return;
        end

        for (int i = 0; i < rdly; i++) begin
            r        = $urandom;
            PC       = r;
            Fetch_go = r[7];
            tick();
            chk("stall_req_valid", imem_req_valid, 1);
            chk("stall_addr",      imem_addr,      pc);
        end
        Fetch_go       = 1'b0;
        imem_req_ready = 1'b1;
        Flush          = (fmode == 2);
        tick();
        imem_req_ready = 1'b0;
        Flush          = 1'b0;
        chk("hs_req_drop", imem_req_valid, 0);
        chk("hs_busy",     Busy,           1);

        if (fmode == 3) begin
            Flush = 1'b1;
            tick();
            Flush = 1'b0;
            chk("f3_busy", Busy, 1);
        end

        for (int i = 0; i < sdly; i++) begin
            tick();
            chk("wait_pc_en", PC_en, 0);
            chk("wait_busy",  Busy,  1);
        end

        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        Flush          = (fmode == 4);
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        Flush          = 1'b0;

        if (fmode == 0) begin
            exp_instr = data;
            exp_valid = 1'b1;
            exp_pcen++;
        end
        chk("rsp_instr",  Instr,       exp_instr);
        chk("rsp_ivalid", Instr_valid, exp_valid);
        chk("rsp_pc_en",  PC_en,       (fmode == 0));
        chk("rsp_busy",   Busy,        0);
        chk("rsp_fault",  Fault,       0);
        tick();
        chk("post_pc_en", PC_en, 0);
    endtask

    initial begin
        logic [31:0] r;
        logic [AW-1:0] rpc;
        int mode;
        int sd;

        idle_inputs();
        PC        = '0;
        Reset_n   = 1'b1;
        exp_instr = '0;
        exp_valid = 1'b0;
        exp_pcen  = 0;
        #2;
        Reset_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        tick();
        Reset_n = 1'b1;
        tick();

        // Basic fetch, one-cycle memory.
        run_fetch(32'h100, 32'hE3A01005, 0, 0, 0);
        // Ready stalled four cycles while PC wanders.
        run_fetch(32'h100, 32'h12345678, 4, 1, 0);
        // Flush in WAIT, response two cycles later is drained and dropped.
        run_fetch(32'h180, 32'hDEADBEEF, 0, 1, 3);
        run_fetch(32'h200, 32'hA5A5F00D, 0, 0, 0);
        // Misaligned PC.
        run_fetch(32'h102, 32'h0, 0, 0, 0);
        // Flush in idle wins over Fetch_go and clears Instr_valid.
        PC       = 32'h300;
        Fetch_go = 1'b1;
        Flush    = 1'b1;
        tick();
        Fetch_go = 1'b0;
        Flush    = 1'b0;
        exp_valid = 1'b0;
        chk("iflush_req_valid", imem_req_valid, 0);
        chk("iflush_busy",      Busy,           0);
        chk("iflush_ivalid",    Instr_valid,    0);
        chk("iflush_instr",     Instr,          exp_instr);
        // Other flush positions.
        run_fetch(32'h400, 32'h11111111, 2, 0, 1);
        run_fetch(32'h404, 32'h22222222, 1, 2, 2);
        run_fetch(32'h408, 32'h33333333, 0, 3, 4);
        run_fetch(32'h40C, 32'h44444444, 0, 3, 0);

        // Randomized transactions.
        for (int k = 0; k < 24; k++) begin
            r   = $urandom;
            rpc = r & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            mode = $urandom_range(0, 4);
            sd   = (mode == 3) ? $urandom_range(0, 2) : $urandom_range(0, 3);
            run_fetch(rpc, $urandom, $urandom_range(0, 3), sd, mode);
        end

        // Reset in the middle of WAIT; late response must be ignored.
        PC       = 32'h500;
        Fetch_go = 1'b1;
        tick();
        Fetch_go       = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        tick();
        Reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        Reset_n = 1'b1;
        exp_instr = '0;
        exp_valid = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFEBABE;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        check_reset_outputs("late_rsp");
        tick();
        chk("late_rsp_pc_en2", PC_en, 0);

        // Timeout: no response for TIMEOUT cycles.
        PC       = 32'h600;
        Fetch_go = 1'b1;
        tick();
        Fetch_go       = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < TMO - 1; i++) begin
            tick();
            chk("tmo_pre_fault", Fault, 0);
            chk("tmo_pre_busy",  Busy,  1);
        end
        tick();
        chk("tmo_fault", Fault, 1);
        chk("tmo_busy",  Busy,  0);
        chk("tmo_pc_en", PC_en, 0);
        PC       = 32'h700;
        Fetch_go = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("err_req_valid", imem_req_valid, 0);
            chk("err_fault",     Fault,          1);
            chk("err_busy",      Busy,           0);
        end
        Fetch_go = 1'b0;
        Reset_n  = 1'b0;
        #1;
        chk("err_rst_fault", Fault, 0);
        tick();
        Reset_n = 1'b1;
        tick();
        run_fetch(32'h800, 32'h0BADC0DE, 1, 1, 0);

        tick();
        chk("pc_en_total", pcen_seen, exp_pcen);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
